// File: rtl/segment_scan_display.sv
// segment_scan_display: time-multiplexed N-digit hex 7-segment driver for shared-segment boards.
// Values are latched once per frame, and digits are separated by optional dead time.
module segment_scan_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 6250,
  parameter int DEAD_CYCLES    = 25,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b0
) (
  input  logic                clk25,
  input  logic                rst_n,
  input  logic                latch,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [6:0]          seg_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  localparam logic [0:0] ST_DEAD  = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;
  localparam logic [0:0] ST_FIRST = (DEAD_CYCLES > 0) ? ST_DEAD : ST_ON;

  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 1) begin : g_param_check
    $error("segment_scan_display: DIGITS must be 1..8 and SCAN_DIV at least 1");
  end

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  logic [0:0]          state_r;
  logic [IW-1:0]       idx_r;
  logic [CW-1:0]       cnt_r;
  logic                run_r;
  logic [4*DIGITS-1:0] shadow_val_r;
  logic [DIGITS-1:0]   shadow_dp_r;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   dig_r;
  logic                tick_r;

  logic [0:0]          nxt_state_s;
  logic [IW-1:0]       nxt_idx_s;
  logic [CW-1:0]       nxt_cnt_s;
  logic                frame_start_s;
  logic                load_s;
  logic [4*DIGITS-1:0] nxt_val_s;
  logic [DIGITS-1:0]   nxt_dp_s;
  logic [4*DIGITS-1:0] upper_s;
  logic [DIGITS-1:0]   dp_vec_s;
  logic [DIGITS-1:0]   onehot_s;
  logic [3:0]          nib_s;
  logic                blank_s;
  logic [6:0]          seg_lit_s;
  logic [6:0]          nxt_seg_s;
  logic                nxt_dp_out_s;
  logic [DIGITS-1:0]   nxt_dig_s;

  // Scan sequencing: the first cycle after reset release is forced to be a frame start.
  always_comb begin
    nxt_state_s   = state_r;
    nxt_idx_s     = idx_r;
    nxt_cnt_s     = cnt_r + CW'(1'b1);
    frame_start_s = 1'b0;
    if (!run_r) begin
      nxt_state_s   = ST_FIRST;
      nxt_idx_s     = {IW{1'b0}};
      nxt_cnt_s     = {CW{1'b0}};
      frame_start_s = 1'b1;
    end else begin
      case (state_r)
        ST_DEAD: begin
          if (cnt_r == DEAD_LAST) begin
            nxt_state_s = ST_ON;
            nxt_cnt_s   = {CW{1'b0}};
          end else begin
            nxt_state_s = ST_DEAD;
          end
        end
        ST_ON: begin
          if (cnt_r == SCAN_LAST) begin
            nxt_state_s = ST_FIRST;
            nxt_cnt_s   = {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
              nxt_idx_s     = {IW{1'b0}};
              frame_start_s = 1'b1;
            end else begin
              nxt_idx_s = idx_r + IW'(1'b1);
            end
          end else begin
            nxt_state_s = ST_ON;
          end
        end
        default: begin
          nxt_state_s = ST_FIRST;
          nxt_idx_s   = {IW{1'b0}};
          nxt_cnt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Output decode from the upcoming state and shadow, so outputs can be registered without lag.
  always_comb begin
    load_s    = frame_start_s & latch;
    nxt_val_s = load_s ? value : shadow_val_r;
    nxt_dp_s  = load_s ? dp_in : shadow_dp_r;
    upper_s   = nxt_val_s >> {nxt_idx_s, 2'b00};
    nib_s     = 4'(upper_s);
    dp_vec_s  = nxt_dp_s >> nxt_idx_s;
    onehot_s  = DIGITS'(1'b1) << nxt_idx_s;
    blank_s   = BLANK_LEADING && (nxt_idx_s != {IW{1'b0}}) && (upper_s == {(4*DIGITS){1'b0}});
    seg_lit_s = blank_s ? 7'h00 : hex7(nib_s);
    if (nxt_state_s == ST_ON) begin
      nxt_seg_s    = seg_lit_s ^ {7{SEG_ACTIVE_LOW}};
      nxt_dp_out_s = dp_vec_s[0] ^ SEG_ACTIVE_LOW;
      nxt_dig_s    = onehot_s ^ {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      nxt_seg_s    = SEG_OFF;
      nxt_dp_out_s = DP_OFF;
      nxt_dig_s    = DIG_OFF;
    end
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_r      <= ST_DEAD;
      idx_r        <= {IW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      run_r        <= 1'b0;
      shadow_val_r <= {(4*DIGITS){1'b0}};
      shadow_dp_r  <= {DIGITS{1'b0}};
      seg_r        <= SEG_OFF;
      dp_r         <= DP_OFF;
      dig_r        <= DIG_OFF;
      tick_r       <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      idx_r        <= nxt_idx_s;
      cnt_r        <= nxt_cnt_s;
      run_r        <= 1'b1;
      shadow_val_r <= nxt_val_s;
      shadow_dp_r  <= nxt_dp_s;
      seg_r        <= nxt_seg_s;
      dp_r         <= nxt_dp_out_s;
      dig_r        <= nxt_dig_s;
      tick_r       <= frame_start_s;
    end
  end

  assign seg_out    = seg_r;
  assign dp_out     = dp_r;
  assign dig_sel    = dig_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_segment_scan_display.sv
// Bench for segment_scan_display: three configurations checked cycle by cycle against a
// slot-arithmetic reference model, plus fixed expectations for the documented scenarios.
module tb_segment_scan_display;

  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;

  logic rst_n_a, latch_a, dpo_a, tick_a;
  logic [15:0] value_a;
  logic [3:0] dp_a, dig_a;
  logic [6:0] seg_a;
  logic rst_n_b, latch_b, dpo_b, tick_b;
  logic [15:0] value_b;
  logic [3:0] dp_b, dig_b;
  logic [6:0] seg_b;
  logic rst_n_c, latch_c, dpo_c, tick_c;
  logic [3:0] value_c;
  logic [0:0] dp_c, dig_c;
  logic [6:0] seg_c;

  segment_scan_display #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                         .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_a (
    .clk25(clk25), .rst_n(rst_n_a), .latch(latch_a), .value(value_a), .dp_in(dp_a),
    .seg_out(seg_a), .dp_out(dpo_a), .dig_sel(dig_a), .frame_tick(tick_a));

  segment_scan_display #(.DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                         .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_b (
    .clk25(clk25), .rst_n(rst_n_b), .latch(latch_b), .value(value_b), .dp_in(dp_b),
    .seg_out(seg_b), .dp_out(dpo_b), .dig_sel(dig_b), .frame_tick(tick_b));

  segment_scan_display #(.DIGITS(1), .SCAN_DIV(1), .DEAD_CYCLES(0), .SEG_ACTIVE_LOW(1'b1),
                         .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_c (
    .clk25(clk25), .rst_n(rst_n_c), .latch(latch_c), .value(value_c), .dp_in(dp_c),
    .seg_out(seg_c), .dp_out(dpo_c), .dig_sel(dig_c), .frame_tick(tick_c));

  // Observed outputs packed as {frame_tick, dig_sel[3:0], dp_out, seg_out}
  logic [12:0] obs_a, obs_b, obs_c;
  assign obs_a = {tick_a, dig_a, dpo_a, seg_a};
  assign obs_b = {tick_b, dig_b, dpo_b, seg_b};
  assign obs_c = {tick_c, 3'b000, dig_c, dpo_c, seg_c};

  int cfg_dig  [3] = '{4, 4, 1};
  int cfg_scan [3] = '{4, 4, 1};
  int cfg_dead [3] = '{2, 2, 0};
  bit cfg_blank[3] = '{1'b0, 1'b1, 1'b0};

  bit          run_m [3];
  int          t_m   [3];
  logic [15:0] sv_m  [3];
  logic [3:0]  sd_m  [3];
  logic [12:0] exp_m [3];

  function automatic logic [3:0] dig_mask(int k);
    return 4'((1 << cfg_dig[k]) - 1);
  endfunction

  function automatic int frame_len(int k);
    return cfg_dig[k] * (cfg_scan[k] + cfg_dead[k]);
  endfunction

  // Expected outputs from the position inside the frame: each digit owns a slot of dead+scan cycles.
  function automatic logic [12:0] model_out(int k);
    int slot, p, d, off;
    logic [3:0] nib, dig;
    logic [6:0] seg;
    bit lead;
    slot = cfg_scan[k] + cfg_dead[k];
    p    = t_m[k] % frame_len(k);
    d    = p / slot;
    off  = p % slot;
    if (off < cfg_dead[k]) return {p == 0, dig_mask(k), 1'b1, 7'h7F};
    nib  = 4'(sv_m[k] >> (4 * d));
    lead = cfg_blank[k] && (d > 0);
    for (int j = d; j < cfg_dig[k]; j++) begin
      if (4'(sv_m[k] >> (4 * j)) != 4'h0) lead = 1'b0;
    end
    seg = lead ? 7'h7F : ~SEG_TAB[nib];
    dig = dig_mask(k) & ~(4'b0001 << d);
    return {p == 0, dig, ~sd_m[k][d], seg};
  endfunction

  // Advance one clock and update the model of all three instances with the inputs seen at that edge.
  task automatic step();
    bit r [3];
    bit l [3];
    logic [15:0] v [3];
    logic [3:0] dv [3];
    r[0] = rst_n_a; r[1] = rst_n_b; r[2] = rst_n_c;
    l[0] = latch_a; l[1] = latch_b; l[2] = latch_c;
    v[0] = value_a; v[1] = value_b; v[2] = {12'h000, value_c};
    dv[0] = dp_a; dv[1] = dp_b; dv[2] = {3'b000, dp_c};
    @(posedge clk25);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!r[k]) begin
        run_m[k] = 1'b0;
        sv_m[k]  = 16'h0000;
        sd_m[k]  = 4'h0;
        exp_m[k] = {1'b0, dig_mask(k), 1'b1, 7'h7F};
      end else begin
        t_m[k]   = run_m[k] ? t_m[k] + 1 : 0;
        run_m[k] = 1'b1;
        if ((t_m[k] % frame_len(k)) == 0 && l[k]) begin
          sv_m[k] = v[k];
          sd_m[k] = dv[k];
        end
        exp_m[k] = model_out(k);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; latch_a = 1'b1; value_a = 16'h1234; dp_a = 4'h0;
    rst_n_b = 1'b0; latch_b = 1'b1; value_b = 16'h0000; dp_b = 4'h0;
    rst_n_c = 1'b0; latch_c = 1'b1; value_c = 4'h0;     dp_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs_a !== {1'b0, 4'hF, 1'b1, 7'h7F}) begin
        errors++;
        $display("FAIL reset_idle: got %h, expected %h", obs_a, {1'b0, 4'hF, 1'b1, 7'h7F});
      end
    end
  endtask

  task automatic test_full_scan();
    int last;
    last = -1;
    rst_n_a = 1'b1;
    for (int c = 0; c < 48; c++) begin
      step();
      checks++;
      if (obs_a !== exp_m[0]) begin
        errors++;
        $display("FAIL scan_model c=%0d: got %h, expected %h", c, obs_a, exp_m[0]);
      end
      if (tick_a === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 24) begin
            errors++;
            $display("FAIL tick_spacing: got %0d, expected 24", c - last);
          end
        end
        last = c;
      end
      case (c % 24)
        2, 8, 14, 20: begin
          checks++;
          if ({dig_a, seg_a} !== ((c % 24 == 2)  ? {4'hE, ~7'h66} :
                                  (c % 24 == 8)  ? {4'hD, ~7'h4F} :
                                  (c % 24 == 14) ? {4'hB, ~7'h5B} : {4'h7, ~7'h06})) begin
            errors++;
            $display("FAIL scan_digit p=%0d: got dig=%h seg=%h", c % 24, dig_a, seg_a);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (last != 24) begin
      errors++;
      $display("FAIL tick_seen: got last tick at %0d, expected 24", last);
    end
  endtask

  task automatic test_tear_free();
    logic [10:0] want;
    for (int i = 0; i < 30 && (t_m[0] % 24) != 23; i++) step();
    latch_a = 1'b1;
    for (int c = 0; c < 72; c++) begin
      if (c == 9)  value_a = 16'hABCD;
      if (c == 48) begin
        latch_a = 1'b0;
        value_a = 16'h5A5A;
      end
      step();
      checks++;
      if (obs_a !== exp_m[0]) begin
        errors++;
        $display("FAIL tear_model c=%0d: got %h, expected %h", c, obs_a, exp_m[0]);
      end
      want = 11'h000;
      case (c)
        14:      want = {4'hB, ~7'h5B};
        20:      want = {4'h7, ~7'h06};
        26, 50:  want = {4'hE, ~7'h5E};
        32:      want = {4'hD, ~7'h39};
        38:      want = {4'hB, ~7'h7C};
        44, 68:  want = {4'h7, ~7'h77};
        default: want = 11'h000;
      endcase
      if (want != 11'h000) begin
        checks++;
        if ({dig_a, seg_a} !== want) begin
          errors++;
          $display("FAIL tear_digit c=%0d: got %h, expected %h", c, {dig_a, seg_a}, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_on();
    for (int i = 0; i < 48 && (t_m[0] % 24) != 15; i++) step();
    rst_n_a = 1'b0;
    latch_a = 1'b0;
    value_a = 16'h4321;
    step();
    checks++;
    if (obs_a !== {1'b0, 4'hF, 1'b1, 7'h7F}) begin
      errors++;
      $display("FAIL reset_mid_on: got %h, expected %h", obs_a, {1'b0, 4'hF, 1'b1, 7'h7F});
    end
    step();
    rst_n_a = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (c == 0) begin
        value_a = 16'h9876;
        latch_a = 1'b1;
      end
      checks++;
      if (obs_a !== exp_m[0]) begin
        errors++;
        $display("FAIL restart_model c=%0d: got %h, expected %h", c, obs_a, exp_m[0]);
      end
      if (c == 0 || c == 2 || c == 26) begin
        checks++;
        if ({tick_a, dig_a, seg_a} !== ((c == 0) ? {1'b1, 4'hF, 7'h7F} :
                                        (c == 2) ? {1'b0, 4'hE, ~7'h3F} : {1'b0, 4'hE, ~7'h7D})) begin
          errors++;
          $display("FAIL restart_digit c=%0d: got tick=%b dig=%h seg=%h", c, tick_a, dig_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_random_a();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) begin
        value_a = 16'($urandom);
        dp_a    = 4'($urandom);
      end
      if ($urandom_range(15) == 0) latch_a = ~latch_a;
      rst_n_a = ($urandom_range(199) != 0);
      step();
      checks++;
      if (obs_a !== exp_m[0]) begin
        errors++;
        $display("FAIL random_model c=%0d: got %h, expected %h", c, obs_a, exp_m[0]);
      end
    end
    rst_n_a = 1'b1;
  endtask

  task automatic test_blanking();
    logic [15:0] masks [5] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h0F0F};
    value_b = 16'h0050; dp_b = 4'b1000; latch_b = 1'b1; rst_n_b = 1'b1;
    for (int c = 0; c < 48; c++) begin
      if (c == 24) begin
        value_b = 16'h0000;
        dp_b    = 4'b0000;
      end
      step();
      checks++;
      if (obs_b !== exp_m[1]) begin
        errors++;
        $display("FAIL blank_model c=%0d: got %h, expected %h", c, obs_b, exp_m[1]);
      end
      if ((c % 6) == 2) begin
        checks++;
        if ({dig_b, dpo_b, seg_b} !== ((c == 2 || c == 26) ? {4'hE, 1'b1, ~7'h3F} :
                                        (c == 8)  ? {4'hD, 1'b1, ~7'h6D} :
                                        (c == 20) ? {4'h7, 1'b0, 7'h7F} :
                                        {4'hF & ~(4'b0001 << ((c % 24) / 6)), 1'b1, 7'h7F})) begin
          errors++;
          $display("FAIL blank_digit c=%0d: got dig=%h dp=%b seg=%h", c, dig_b, dpo_b, seg_b);
        end
      end
    end
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5) == 0) begin
        value_b = 16'($urandom) & masks[$urandom_range(4)];
        dp_b    = 4'($urandom);
        latch_b = 1'($urandom);
      end
      step();
      checks++;
      if (obs_b !== exp_m[1]) begin
        errors++;
        $display("FAIL blank_random c=%0d: got %h, expected %h", c, obs_b, exp_m[1]);
      end
    end
  endtask

  task automatic test_no_dead();
    logic [3:0] shown;
    rst_n_c = 1'b1;
    latch_c = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 40) latch_c = 1'b0;
      if (c < 40) shown = value_c;
      value_c = 4'($urandom);
      dp_c    = 1'($urandom);
      if (c < 40) shown = value_c;
      step();
      checks++;
      if (obs_c !== exp_m[2]) begin
        errors++;
        $display("FAIL nodead_model c=%0d: got %h, expected %h", c, obs_c, exp_m[2]);
      end
      checks++;
      if ({tick_c, dig_c, seg_c} !== {1'b1, 1'b0, ~SEG_TAB[shown]}) begin
        errors++;
        $display("FAIL nodead_digit c=%0d: got tick=%b dig=%b seg=%h, expected seg=%h",
                 c, tick_c, dig_c, seg_c, ~SEG_TAB[shown]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_tear_free();
    test_reset_mid_on();
    test_random_a();
    test_blanking();
    test_no_dead();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
